// File: rtl/word_query_ctrl.sv
// Word query controller: collects classified letters into a word buffer,
// hands the finished word to the Dictionary, waits for its answer (with a
// fallback to the raw word on timeout) and presents the result to a
// consumer through a valid/ready handshake.
module word_query_ctrl #(
    parameter int MAX_CHARS = 15,
    parameter int CHAR_W    = 8,
    parameter int TIMEOUT   = 400000
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_char_valid,
    input  logic [CHAR_W-1:0]           i_char,
    output logic                        o_char_ready,
    input  logic                        i_eow,
    input  logic                        i_abort,
    output logic                        o_dict_start,
    output logic [MAX_CHARS*CHAR_W-1:0] o_dict_word,
    input  logic                        i_dict_finish,
    input  logic [MAX_CHARS*CHAR_W-1:0] i_dict_word,
    output logic                        o_result_valid,
    output logic [MAX_CHARS*CHAR_W-1:0] o_result_word,
    input  logic                        i_result_ready,
    output logic                        o_timeout,
    output logic                        o_overflow,
    output logic [3:0]                  o_len,
    output logic                        o_busy
);

    localparam int WORD_W = MAX_CHARS * CHAR_W;
    // Timer only ever counts up to TIMEOUT-1, so this width never wraps.
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [3:0]       LEN_MAX  = 4'(MAX_CHARS);

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_OUTPUT  = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    state_t              state_r, state_n;
    logic [WORD_W-1:0]   buf_r, buf_n;
    logic [3:0]          len_r, len_n;
    logic                ovf_r, ovf_n;
    logic [TMR_W-1:0]    tmr_r, tmr_n;
    logic                start_r, start_n;
    logic                rv_r, rv_n;
    logic [WORD_W-1:0]   rword_r, rword_n;
    logic                tout_r, tout_n;
    logic                busy_r, busy_n;

    logic                ready_s;
    logic                take_s;
    logic                room_s;
    logic                accept_s;
    logic                drop_s;
    logic [3:0]          len_plus_s;
    logic                tmr_last_s;
    logic [TMR_W-1:0]    tmr_inc_s;

    // Letters are only taken while collecting and never during reset.
    assign ready_s    = (state_r == ST_COLLECT) && !i_rst_n;
    // Code 0 is padding: it is never stored and never counts as overflow.
    assign take_s     = i_char_valid && ready_s && (|i_char);
    assign room_s     = (len_r < LEN_MAX);
    assign accept_s   = take_s && room_s && !i_abort;
    assign drop_s     = take_s && !room_s && !i_abort;
    assign len_plus_s = accept_s ? (len_r + 4'd1) : len_r;
    assign tmr_last_s = (tmr_r == TMR_LAST);
    // Saturate so an abort on the terminal cycle cannot wrap the timer.
    assign tmr_inc_s  = tmr_last_s ? tmr_r : (tmr_r + TMR_W'(1));

    assign o_char_ready   = ready_s;
    assign o_dict_start   = start_r;
    assign o_dict_word    = buf_r;
    assign o_result_valid = rv_r;
    assign o_result_word  = rword_r;
    assign o_timeout      = tout_r;
    assign o_overflow     = ovf_r;
    assign o_len          = len_r;
    assign o_busy         = busy_r;

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            state_r <= ST_COLLECT;
            buf_r   <= {WORD_W{1'b0}};
            len_r   <= 4'd0;
            ovf_r   <= 1'b0;
            tmr_r   <= {TMR_W{1'b0}};
            start_r <= 1'b0;
            rv_r    <= 1'b0;
            rword_r <= {WORD_W{1'b0}};
            tout_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            buf_r   <= buf_n;
            len_r   <= len_n;
            ovf_r   <= ovf_n;
            tmr_r   <= tmr_n;
            start_r <= start_n;
            rv_r    <= rv_n;
            rword_r <= rword_n;
            tout_r  <= tout_n;
            busy_r  <= busy_n;
        end
    end

    // Next-state selection; abort beats every other same-cycle event.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_COLLECT: begin
                if (i_abort) begin
                    state_n = ST_COLLECT;
                end else if (i_eow && (len_plus_s != 4'd0)) begin
                    state_n = ST_LAUNCH;
                end else begin
                    state_n = ST_COLLECT;
                end
            end
            ST_LAUNCH: begin
                if (i_abort) begin
                    state_n = ST_DRAIN;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_abort) begin
                    state_n = ST_DRAIN;
                end else if (i_dict_finish || tmr_last_s) begin
                    state_n = ST_OUTPUT;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_OUTPUT: begin
                if (i_abort || i_result_ready) begin
                    state_n = ST_COLLECT;
                end else begin
                    state_n = ST_OUTPUT;
                end
            end
            ST_DRAIN: begin
                if (i_dict_finish || tmr_last_s) begin
                    state_n = ST_COLLECT;
                end else begin
                    state_n = ST_DRAIN;
                end
            end
            default: begin
                state_n = ST_COLLECT;
            end
        endcase
    end

    // Next values of the word buffer, timer and result/status outputs.
    always_comb begin
        buf_n   = buf_r;
        len_n   = len_r;
        ovf_n   = ovf_r;
        tmr_n   = tmr_r;
        start_n = 1'b0;
        rv_n    = rv_r;
        rword_n = rword_r;
        tout_n  = tout_r;
        busy_n  = (state_n != ST_COLLECT);
        case (state_r)
            ST_COLLECT: begin
                if (i_abort) begin
                    buf_n = {WORD_W{1'b0}};
                    len_n = 4'd0;
                    ovf_n = 1'b0;
                    rv_n  = 1'b0;
                end else begin
                    // Target slot is still zero, so OR-ing places the letter.
                    if (accept_s) begin
                        buf_n = buf_r | (WORD_W'(i_char) << (len_r * CHAR_W));
                        len_n = len_plus_s;
                    end else begin
                        buf_n = buf_r;
                    end
                    if (drop_s) begin
                        ovf_n = 1'b1;
                    end else begin
                        ovf_n = ovf_r;
                    end
                    if (state_n == ST_LAUNCH) begin
                        start_n = 1'b1;
                    end else begin
                        start_n = 1'b0;
                    end
                end
            end
            ST_LAUNCH: begin
                tmr_n = {TMR_W{1'b0}};
            end
            ST_WAIT: begin
                if (i_abort) begin
                    tmr_n = tmr_inc_s;
                end else if (i_dict_finish) begin
                    rword_n = i_dict_word;
                    tout_n  = 1'b0;
                    rv_n    = 1'b1;
                end else if (tmr_last_s) begin
                    rword_n = buf_r;
                    tout_n  = 1'b1;
                    rv_n    = 1'b1;
                end else begin
                    tmr_n = tmr_inc_s;
                end
            end
            ST_OUTPUT: begin
                if (i_abort || i_result_ready) begin
                    buf_n = {WORD_W{1'b0}};
                    len_n = 4'd0;
                    ovf_n = 1'b0;
                    rv_n  = 1'b0;
                end else begin
                    rv_n = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (i_dict_finish || tmr_last_s) begin
                    buf_n = {WORD_W{1'b0}};
                    len_n = 4'd0;
                    ovf_n = 1'b0;
                end else begin
                    tmr_n = tmr_inc_s;
                end
            end
            default: begin
                buf_n = buf_r;
            end
        endcase
    end

endmodule

// File: tb/tb_word_query_ctrl.sv
// Bench for word_query_ctrl: directed letter/lookup scenarios, a word-level
// reference model compared every cycle, plus literal expectations.
module tb_word_query_ctrl;

    localparam int MC  = 15;
    localparam int CW  = 8;
    localparam int TMO = 100;
    localparam int W   = MC * CW;

    localparam int PH_IDLE   = 0;
    localparam int PH_LAUNCH = 1;
    localparam int PH_WAIT   = 2;
    localparam int PH_RESULT = 3;
    localparam int PH_DRAIN  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cval = 1'b0;
    logic [CW-1:0] chr = '0;
    logic          eow = 1'b0;
    logic          abort = 1'b0;
    logic          fin = 1'b0;
    logic [W-1:0]  dword = '0;
    logic          rdy = 1'b0;

    logic          o_char_ready;
    logic          o_dict_start;
    logic [W-1:0]  o_dict_word;
    logic          o_result_valid;
    logic [W-1:0]  o_result_word;
    logic          o_timeout;
    logic          o_overflow;
    logic [3:0]    o_len;
    logic          o_busy;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int rv_cnt = 0;

    // reference model state
    logic [CW-1:0] letters[$];
    int            ph = PH_IDLE;
    int            waited = 0;
    logic          m_ovf = 1'b0;
    logic [W-1:0]  m_rword = '0;
    logic          m_tout = 1'b0;

    word_query_ctrl #(.MAX_CHARS(MC), .CHAR_W(CW), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst_n(rst),
        .i_char_valid(cval), .i_char(chr), .o_char_ready(o_char_ready),
        .i_eow(eow), .i_abort(abort),
        .o_dict_start(o_dict_start), .o_dict_word(o_dict_word),
        .i_dict_finish(fin), .i_dict_word(dword),
        .o_result_valid(o_result_valid), .o_result_word(o_result_word),
        .i_result_ready(rdy), .o_timeout(o_timeout),
        .o_overflow(o_overflow), .o_len(o_len), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pack_word();
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < letters.size(); i++) w[i*CW +: CW] = letters[i];
        return w;
    endfunction

    task automatic clear_word();
        letters.delete();
        m_ovf = 1'b0;
    endtask

    // One clock of the word-level behaviour, from the inputs seen at the edge.
    task automatic model_step();
        if (rst) begin
            clear_word();
            ph = PH_IDLE; waited = 0; m_rword = '0; m_tout = 1'b0;
        end else begin
            case (ph)
                PH_IDLE: begin
                    if (abort) clear_word();
                    else begin
                        if (cval && chr != 0) begin
                            if (letters.size() < MC) letters.push_back(chr);
                            else m_ovf = 1'b1;
                        end
                        if (eow && letters.size() > 0) ph = PH_LAUNCH;
                    end
                end
                PH_LAUNCH: begin
                    waited = 0;
                    ph = abort ? PH_DRAIN : PH_WAIT;
                end
                PH_WAIT: begin
                    waited++;
                    if (abort) ph = PH_DRAIN;
                    else if (fin) begin m_rword = dword; m_tout = 1'b0; ph = PH_RESULT; end
                    else if (waited == TMO) begin m_rword = pack_word(); m_tout = 1'b1; ph = PH_RESULT; end
                end
                PH_RESULT: begin
                    if (abort || rdy) begin clear_word(); ph = PH_IDLE; end
                end
                PH_DRAIN: begin
                    waited++;
                    if (fin || waited >= TMO) begin clear_word(); ph = PH_IDLE; end
                end
                default: ph = PH_IDLE;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison against the model, mid-cycle.
    initial forever begin
        @(negedge clk);
        if (o_dict_start === 1'b1) start_cnt++;
        if (o_result_valid === 1'b1) rv_cnt++;
        chk("cyc_char_ready", o_char_ready, (ph == PH_IDLE) && !rst);
        chk("cyc_dict_start", o_dict_start, ph == PH_LAUNCH);
        chk("cyc_dict_word", o_dict_word, pack_word());
        chk("cyc_len", o_len, letters.size());
        chk("cyc_overflow", o_overflow, m_ovf);
        chk("cyc_busy", o_busy, ph != PH_IDLE);
        chk("cyc_result_valid", o_result_valid, ph == PH_RESULT);
        chk("cyc_result_word", o_result_word, m_rword);
        chk("cyc_timeout", o_timeout, m_tout);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [CW-1:0] v);
        cval = 1'b1; chr = v;
        tick();
        cval = 1'b0; chr = '0;
    endtask

    task automatic commit();
        eow = 1'b1;
        tick();
        eow = 1'b0;
    endtask

    task automatic finish_with(input logic [W-1:0] w);
        fin = 1'b1; dword = w;
        tick();
        fin = 1'b0; dword = '0;
    endtask

    task automatic handshake();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
    endtask

    logic [7:0] t1 [7] = '{8'd7, 8'd1, 8'd12, 8'd12, 8'd5, 8'd18, 8'd25};
    logic [W-1:0] w1 = 120'h0000_1122_3344_5566_7788_99AA_BBCC;
    logic [W-1:0] w3 = 120'h0000_0000_0000_0000_0000_0005_0F04;
    int n;
    int rv_base;
    int st_base;

    initial begin
        tick(); tick();
        chk("rst_char_ready", o_char_ready, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_len", o_len, 4'd0);
        rst = 1'b0;
        tick();
        chk("idle_char_ready", o_char_ready, 1'b1);

        // word "gallery" and a dictionary answer after 30 cycles
        foreach (t1[i]) send(t1[i]);
        commit();
        chk("t1_start", o_dict_start, 1'b1);
        chk("t1_dict_word", o_dict_word, 120'h19_1205_0C0C_0107);
        chk("t1_len", o_len, 4'd7);
        repeat (30) tick();
        chk("t1_wait_no_valid", o_result_valid, 1'b0);
        finish_with(w1);
        chk("t1_valid", o_result_valid, 1'b1);
        chk("t1_word", o_result_word, w1);
        chk("t1_timeout", o_timeout, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t1_hold_word", o_result_word, w1);
            chk("t1_hold_valid", o_result_valid, 1'b1);
        end
        handshake();
        chk("t1_done_valid", o_result_valid, 1'b0);
        chk("t1_done_len", o_len, 4'd0);
        chk("t1_done_ready", o_char_ready, 1'b1);
        chk("t1_start_count", start_cnt, 1);

        // padding letter, then 17 letters -> overflow
        send(8'd1); send(8'd2); send(8'd3);
        send(8'd0);
        chk("t2_zero_len", o_len, 4'd3);
        chk("t2_zero_ovf", o_overflow, 1'b0);
        for (int v = 4; v <= 17; v++) send(v[7:0]);
        commit();
        chk("t2_len", o_len, 4'd15);
        chk("t2_ovf", o_overflow, 1'b1);
        chk("t2_word", o_dict_word, 120'h0F0E_0D0C_0B0A_0908_0706_0504_0302_01);
        repeat (3) tick();
        finish_with(w1);
        handshake();
        chk("t2_ovf_clear", o_overflow, 1'b0);

        // no answer -> timeout fallback carrying the raw word
        send(8'd3); send(8'd1); send(8'd20);
        commit();
        chk("t3_start", o_dict_start, 1'b1);
        n = 0;
        while (o_result_valid !== 1'b1 && n < 300) begin tick(); n++; end
        chk("t3_latency", n, TMO + 1);
        chk("t3_timeout", o_timeout, 1'b1);
        chk("t3_word", o_result_word, 120'h14_0103);
        handshake();

        // finish on the terminal wait cycle wins over timeout
        send(8'd4); send(8'd15); send(8'd7);
        commit();
        repeat (TMO) tick();
        chk("t4_term_no_valid", o_result_valid, 1'b0);
        finish_with(w3);
        chk("t4_valid", o_result_valid, 1'b1);
        chk("t4_timeout", o_timeout, 1'b0);
        chk("t4_word", o_result_word, w3);
        handshake();

        // abort at wait cycle 3, finish at wait cycle 10
        rv_base = rv_cnt;
        send(8'd2); send(8'd5); send(8'd5);
        commit();
        repeat (3) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t5_drain_busy", o_busy, 1'b1);
        repeat (6) tick();
        chk("t5_drain_not_ready", o_char_ready, 1'b0);
        finish_with(w1);
        chk("t5_back_ready", o_char_ready, 1'b1);
        chk("t5_back_len", o_len, 4'd0);
        chk("t5_no_result", rv_cnt - rv_base, 0);

        // letter with eow at length 0, then abort during launch
        cval = 1'b1; chr = 8'd9; eow = 1'b1;
        tick();
        cval = 1'b0; chr = '0; eow = 1'b0;
        chk("t6_len", o_len, 4'd1);
        chk("t6_start", o_dict_start, 1'b1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t6_start_once", o_dict_start, 1'b0);
        chk("t6_busy", o_busy, 1'b1);
        repeat (4) tick();
        finish_with(w1);
        chk("t6_idle", o_busy, 1'b0);
        chk("t6_no_result", rv_cnt - rv_base, 0);

        // abort beats a letter in collect, and beats the handshake in output
        send(8'd1); send(8'd2);
        cval = 1'b1; chr = 8'd3; abort = 1'b1;
        tick();
        cval = 1'b0; chr = '0; abort = 1'b0;
        chk("t7_abort_len", o_len, 4'd0);
        send(8'd8);
        commit();
        tick();
        finish_with(w1);
        chk("t7_valid", o_result_valid, 1'b1);
        abort = 1'b1; rdy = 1'b1;
        tick();
        abort = 1'b0; rdy = 1'b0;
        chk("t7_abort_valid", o_result_valid, 1'b0);
        chk("t7_abort_len", o_len, 4'd0);

        // reset mid-lookup, late finish, empty commit
        send(8'd6); send(8'd9);
        commit();
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("t8_rst_ready", o_char_ready, 1'b0);
        chk("t8_rst_busy", o_busy, 1'b0);
        chk("t8_rst_len", o_len, 4'd0);
        chk("t8_rst_dword", o_dict_word, '0);
        chk("t8_rst_rword", o_result_word, '0);
        chk("t8_rst_start", o_dict_start, 1'b0);
        chk("t8_rst_valid", o_result_valid, 1'b0);
        rst = 1'b0;
        finish_with(w1);
        chk("t8_late_finish_idle", o_busy, 1'b0);
        chk("t8_late_finish_valid", o_result_valid, 1'b0);
        st_base = start_cnt;
        commit();
        chk("t8_empty_eow_start", o_dict_start, 1'b0);
        tick();
        chk("t8_empty_eow_busy", o_busy, 1'b0);
        chk("t8_empty_eow_count", start_cnt - st_base, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/word_query_ctrl.md
WORD_QUERY_CTRL -- requirements
Module: word_query_ctrl

Interface
REQ-001 SHALL have parameter MAX_CHARS, default 15, meaning the maximum number of letters per word.
REQ-002 SHALL have parameter CHAR_W, default 8, meaning the width of one letter code (a=1..z=26; 0 is reserved padding).
REQ-003 SHALL have parameter TIMEOUT, default 400000, meaning the number of cycles allowed for a Dictionary lookup.
REQ-004 SHALL have port i_clk  in  1  sole clock; all logic is on the rising edge.
REQ-005 SHALL have port i_rst_n  in  1  reset, synchronous and active-high (asserted = 1) despite the suffix.
REQ-006 SHALL have port i_char_valid  in  1  letter strobe from the gesture classifier.
REQ-007 SHALL have port i_char  in  CHAR_W  letter code.
REQ-008 SHALL have port o_char_ready  out  1  letter accept.
REQ-009 SHALL have port i_eow  in  1  end-of-word commit pulse.
REQ-010 SHALL have port i_abort  in  1  discard the current word or lookup.
REQ-011 SHALL have port o_dict_start  out  1  one-cycle Dictionary start.
REQ-012 SHALL have port o_dict_word  out  MAX_CHARS*CHAR_W  word to the Dictionary; letter k occupies bits [k*CHAR_W +: CHAR_W], first letter at the LSB, unused letters 0.
REQ-013 SHALL have port i_dict_finish  in  1  Dictionary done (level).
REQ-014 SHALL have port i_dict_word  in  MAX_CHARS*CHAR_W  corrected word from the Dictionary.
REQ-015 SHALL have port o_result_valid  out  1  result available.
REQ-016 SHALL have port o_result_word  out  MAX_CHARS*CHAR_W  result word.
REQ-017 SHALL have port i_result_ready  in  1  result consumer accept.
REQ-018 SHALL have port o_timeout  out  1  result is a fallback after timeout.
REQ-019 SHALL have port o_overflow  out  1  at least one letter was dropped from the current word.
REQ-020 SHALL have port o_len  out  4  number of letters buffered.
REQ-021 SHALL have port o_busy  out  1  asserted whenever state != COLLECT.

Function
REQ-022 SHALL implement the states COLLECT, LAUNCH, WAIT, OUTPUT and DRAIN.
REQ-023 SHALL drive o_char_ready = 1 only in COLLECT and not while reset is asserted.
REQ-024 In COLLECT, on i_char_valid && o_char_ready with i_char != 0 and o_len < MAX_CHARS, SHALL store the letter at index o_len and increment o_len.
REQ-025 SHALL discard a letter that arrives when o_len == MAX_CHARS and set o_overflow, which stays set until the buffer clears; a letter of value 0 SHALL be dropped silently.
REQ-026 On i_eow in COLLECT, SHALL go to LAUNCH when o_len > 0 (after including any letter accepted in the same cycle) and ignore i_eow otherwise.
REQ-027 In LAUNCH, SHALL assert o_dict_start for exactly one cycle and go to WAIT; o_dict_word SHALL stay stable from LAUNCH until OUTPUT is exited.
REQ-028 WAIT timer: SHALL clear it on entry to WAIT and increment it once per cycle; i_dict_finish SHALL be ignored in the LAUNCH cycle and honoured from the first WAIT cycle onward.
REQ-029 On i_dict_finish in WAIT, SHALL register i_dict_word into o_result_word, set o_timeout = 0 and go to OUTPUT.
REQ-030 When the timer reaches TIMEOUT-1 without i_dict_finish, SHALL load o_result_word with the buffered word, set o_timeout = 1 and go to OUTPUT; if finish and timeout occur in the same cycle, finish SHALL win.
REQ-031 In OUTPUT, SHALL hold o_result_valid = 1 and keep the result stable until i_result_ready.
REQ-032 On the i_result_ready handshake, SHALL clear the buffer, o_len and o_overflow, deassert o_result_valid, and return to COLLECT on the next cycle.
REQ-033 i_abort in COLLECT or OUTPUT SHALL clear the buffer, o_len, o_overflow and o_result_valid and go to COLLECT; i_abort takes priority over any same-cycle letter, i_eow or handshake.
REQ-034 i_abort in LAUNCH or WAIT SHALL suppress any result: LAUNCH still pulses o_dict_start and then enters DRAIN, and WAIT enters DRAIN directly.
REQ-035 DRAIN SHALL wait for i_dict_finish or the timer terminal (the timer continues from WAIT), then clear the buffer, o_len and o_overflow and go to COLLECT without asserting o_result_valid.
REQ-036 SHALL size the timer to ceil(log2(TIMEOUT)) bits so that it never wraps.

Reset
REQ-037 While i_rst_n = 1 at a rising edge, SHALL set state to COLLECT, clear the buffer, o_len, the timer, o_dict_start, o_result_valid, o_result_word, o_timeout and o_overflow, and hold o_dict_word at 0.
REQ-038 Reset SHALL override every input in any state, including mid-lookup; a late i_dict_finish after reset SHALL be ignored because the state is COLLECT.

Verification
REQ-039 Feed letters 7,1,12,12,5,18,25, then i_eow -> one o_dict_start pulse; o_dict_word = 120'h19_1205_0C0C_0107; o_len = 7.
REQ-040 Dictionary returns finish 30 cycles after start with word W -> o_result_valid with o_result_word = W and o_timeout = 0; hold i_result_ready = 0 for 5 cycles -> result stable; then ready -> COLLECT and o_len = 0.
REQ-041 Feed 17 letters then i_eow -> first 15 stored, o_overflow = 1, o_len = 15; o_overflow clears after the handshake.
REQ-042 No finish with TIMEOUT = 100 -> OUTPUT entered 100 cycles after LAUNCH, o_timeout = 1, o_result_word equals the buffered word; finish on the terminal cycle -> o_timeout = 0.
REQ-043 i_abort at WAIT cycle 3, finish at cycle 10 -> DRAIN; no o_result_valid; COLLECT and o_char_ready = 1 the next cycle.
REQ-044 Reset asserted in WAIT, and i_eow with o_len = 0 -> all outputs 0 and no o_dict_start.
